// File: rtl/johnson_phase_tracker_pkg.sv
// -----------------------------------------------------------------------------
// johnson_pkg
// Shared definitions for the Johnson phase tracker: default parameter values,
// the lock FSM state encoding and a helper that regenerates the Johnson code
// for a given phase index.
// -----------------------------------------------------------------------------
package johnson_pkg;

  localparam int DEF_N          = 4;
  localparam int DEF_LOCK_CNT   = 4;
  localparam int DEF_MISS_LIMIT = 2;
  localparam int DEF_ERR_W      = 8;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } track_state_e;

  // Johnson code (MSB-first) of phase k for an n-stage counter, right-aligned
  // in 32 bits. Phases 0..n fill ones from the MSB down; phases n+1..2n-1
  // leave a run of ones at the LSB end that shrinks by one per step.
  function automatic logic [31:0] johnson_code(input int n, input int k);
    logic [31:0] c;
    c = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) begin
        if (k <= n) begin
          c[i] = (i >= (n - k));
        end else begin
          c[i] = (i < (2 * n - k));
        end
      end else begin
        c[i] = 1'b0;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/johnson_phase_tracker_if.sv
// -----------------------------------------------------------------------------
// johnson_phase_tracker_if
// Bus between the Johnson counter sampling side and the phase tracker.
//   count/count_valid          : Johnson code sample and its qualifier
//   phase/phase_onehot         : decoded phase index and its one-hot form
//   phase_valid                : last sample was a legal Johnson code
//   locked/err_pulse/err_count : lock status and error reporting
// master = sample source / status consumer, slave = tracker.
// -----------------------------------------------------------------------------
interface johnson_phase_tracker_if
  import johnson_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int ERR_W = DEF_ERR_W
);
  localparam int PW = $clog2(2 * N);

  logic [N-1:0]     count;
  logic             count_valid;
  logic [PW-1:0]    phase;
  logic [2*N-1:0]   phase_onehot;
  logic             phase_valid;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;

  modport master (
    output count, count_valid,
    input  phase, phase_onehot, phase_valid, locked, err_pulse, err_count
  );

  modport slave (
    input  count, count_valid,
    output phase, phase_onehot, phase_valid, locked, err_pulse, err_count
  );
endinterface

// File: rtl/johnson_phase_tracker_decode.sv
// -----------------------------------------------------------------------------
// johnson_decode
// Combinational decode of an N-stage Johnson code into a phase index.
//   count : Johnson code sample (MSB-first)
//   k     : phase index 0..2N-1 derived from the MSB and the popcount
//   legal : count is exactly the Johnson code of k (single contiguous run)
// -----------------------------------------------------------------------------
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int PW = $clog2(2 * N)
) (
  input  logic [N-1:0]  count,
  output logic [PW-1:0] k,
  output logic          legal
);

  int pc_s;
  int kk_s;

  // Popcount-based phase guess, then legality by regenerating the code.
  always_comb begin
    pc_s = 0;
    for (int i = 0; i < N; i++) begin
      pc_s = pc_s + int'({31'd0, count[i]});
    end
    if (count[N-1]) begin
      kk_s = pc_s;
    end else if (pc_s != 0) begin
      kk_s = 2 * N - pc_s;
    end else begin
      kk_s = 0;
    end
    k     = PW'(kk_s);
    legal = (32'(count) == johnson_code(N, kk_s));
  end

endmodule

// File: rtl/johnson_phase_tracker.sv
// -----------------------------------------------------------------------------
// johnson_phase_tracker
// Samples an upstream Johnson counter, decodes phase, checks the sample
// against the expected next phase and runs a lock FSM.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : johnson_phase_tracker_if.slave (count in, phase/status out)
// All outputs are registered, one cycle after the sampling edge.
// -----------------------------------------------------------------------------
module johnson_phase_tracker
  import johnson_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int MISS_LIMIT = DEF_MISS_LIMIT,
  parameter int ERR_W      = DEF_ERR_W
) (
  input logic                    clk,
  input logic                    reset_n,
  johnson_phase_tracker_if.slave bus
);

  localparam int PW = $clog2(2 * N);
  localparam int MW = $clog2(LOCK_CNT + 1) + 1;
  localparam int SW = $clog2(MISS_LIMIT + 1);

  localparam logic [PW-1:0]    LAST_PHASE = PW'(2 * N - 1);
  localparam logic [PW-1:0]    PHASE_ONE  = PW'(1);
  localparam logic [MW-1:0]    MATCH_ONE  = MW'(1);
  localparam logic [MW-1:0]    MATCH_LOCK = MW'(LOCK_CNT);
  localparam logic [SW-1:0]    MISS_ONE   = SW'(1);
  localparam logic [SW-1:0]    MISS_LIM   = SW'(MISS_LIMIT);
  localparam logic [ERR_W-1:0] ERR_ONE    = ERR_W'(1);
  localparam logic [2*N-1:0]   OH_ONE     = (2 * N)'(1);

  logic [PW-1:0]    k_s;
  logic             legal_s;
  logic             in_seq_s;
  logic [PW-1:0]    next_exp_s;

  track_state_e     state_r,     state_s;
  logic [MW-1:0]    match_cnt_r, match_cnt_s;
  logic [SW-1:0]    miss_cnt_r,  miss_cnt_s;
  logic [PW-1:0]    expected_r,  expected_s;
  logic [PW-1:0]    phase_r,     phase_s;
  logic [2*N-1:0]   onehot_r,    onehot_s;
  logic             pvalid_r,    pvalid_s;
  logic             locked_r;
  logic             err_pulse_r, err_pulse_s;
  logic [ERR_W-1:0] err_count_r, err_count_s;

  johnson_decode #(.N(N), .PW(PW)) u_decode (
    .count (bus.count),
    .k     (k_s),
    .legal (legal_s)
  );

  assign in_seq_s   = legal_s && (k_s == expected_r);
  assign next_exp_s = (k_s == LAST_PHASE) ? {PW{1'b0}} : (k_s + PHASE_ONE);

  // Next-state, counters and output values for the current sample.
  always_comb begin
    state_s     = state_r;
    match_cnt_s = match_cnt_r;
    miss_cnt_s  = miss_cnt_r;
    expected_s  = expected_r;
    phase_s     = phase_r;
    onehot_s    = onehot_r;
    pvalid_s    = pvalid_r;
    err_pulse_s = 1'b0;   // a pulse never outlives its sample, even if valid drops
    err_count_s = err_count_r;

    if (bus.count_valid) begin
      // Every legal sample re-seeds the expectation, so a phase slip costs one miss.
      if (legal_s) begin
        phase_s    = k_s;
        onehot_s   = OH_ONE << k_s;
        pvalid_s   = 1'b1;
        expected_s = next_exp_s;
      end else begin
        pvalid_s   = 1'b0;
      end

      case (state_r)
        UNLOCKED: begin
          if (legal_s) begin
            state_s     = ACQUIRE;
            match_cnt_s = MATCH_ONE;
          end else begin
            state_s     = UNLOCKED;
          end
        end
        ACQUIRE: begin
          // match_cnt includes the seed sample, so LOCK_CNT in-sequence samples
          // are seen when it already reads LOCK_CNT on an in-sequence sample.
          if (in_seq_s) begin
            if (match_cnt_r >= MATCH_LOCK) begin
              state_s     = LOCKED;
              match_cnt_s = {MW{1'b0}};
              miss_cnt_s  = {SW{1'b0}};
            end else begin
              match_cnt_s = match_cnt_r + MATCH_ONE;
            end
          end else if (legal_s) begin
            match_cnt_s = MATCH_ONE;
          end else begin
            state_s     = UNLOCKED;
            match_cnt_s = {MW{1'b0}};
          end
        end
        LOCKED: begin
          if (in_seq_s) begin
            miss_cnt_s = {SW{1'b0}};
          end else begin
            err_pulse_s = 1'b1;
            if (err_count_r != {ERR_W{1'b1}}) begin
              err_count_s = err_count_r + ERR_ONE;
            end else begin
              err_count_s = err_count_r;
            end
            if ((miss_cnt_r + MISS_ONE) >= MISS_LIM) begin
              state_s    = UNLOCKED;
              miss_cnt_s = {SW{1'b0}};
            end else begin
              miss_cnt_s = miss_cnt_r + MISS_ONE;
            end
          end
        end
        default: begin
          state_s     = UNLOCKED;
          match_cnt_s = {MW{1'b0}};
          miss_cnt_s  = {SW{1'b0}};
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= UNLOCKED;
      match_cnt_r <= {MW{1'b0}};
      miss_cnt_r  <= {SW{1'b0}};
      expected_r  <= {PW{1'b0}};
      phase_r     <= {PW{1'b0}};
      onehot_r    <= {(2*N){1'b0}};
      pvalid_r    <= 1'b0;
      locked_r    <= 1'b0;
      err_pulse_r <= 1'b0;
      err_count_r <= {ERR_W{1'b0}};
    end else begin
      state_r     <= state_s;
      match_cnt_r <= match_cnt_s;
      miss_cnt_r  <= miss_cnt_s;
      expected_r  <= expected_s;
      phase_r     <= phase_s;
      onehot_r    <= onehot_s;
      pvalid_r    <= pvalid_s;
      locked_r    <= (state_s == LOCKED);
      err_pulse_r <= err_pulse_s;
      err_count_r <= err_count_s;
    end
  end

  assign bus.phase        = phase_r;
  assign bus.phase_onehot = onehot_r;
  assign bus.phase_valid  = pvalid_r;
  assign bus.locked       = locked_r;
  assign bus.err_pulse    = err_pulse_r;
  assign bus.err_count    = err_count_r;

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// -----------------------------------------------------------------------------
// tb_johnson_phase_tracker
// Directed bench for johnson_phase_tracker (N=4, LOCK_CNT=4, MISS_LIMIT=2,
// ERR_W=8). Expected values come from a hand-written code table and
// hand-computed outcomes.
// -----------------------------------------------------------------------------
module tb_johnson_phase_tracker;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  logic [3:0] codes [8];

  johnson_phase_tracker_if #(.N(4), .ERR_W(8)) bus ();

  johnson_phase_tracker #(
    .N(4), .LOCK_CNT(4), .MISS_LIMIT(2), .ERR_W(8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one sample, let it be taken on the next edge, settle 1 time unit.
  task automatic sample(input logic [3:0] c, input logic v);
    bus.count       = c;
    bus.count_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_phase"},  32'(bus.phase),        32'd0);
    check({tag, "_onehot"}, 32'(bus.phase_onehot), 32'd0);
    check({tag, "_pvalid"}, 32'(bus.phase_valid),  32'd0);
    check({tag, "_locked"}, 32'(bus.locked),       32'd0);
    check({tag, "_errp"},   32'(bus.err_pulse),    32'd0);
    check({tag, "_errc"},   32'(bus.err_count),    32'd0);
  endtask

  task automatic do_reset();
    reset_n         = 1'b0;
    bus.count       = 4'b0000;
    bus.count_valid = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    reset_n = 1'b1;
    #2;
  endtask

  initial begin
    int k;
    int ph;
    clk      = 1'b0;
    n_checks = 0;
    n_errors = 0;
    codes[0] = 4'b0000; codes[1] = 4'b1000; codes[2] = 4'b1100; codes[3] = 4'b1110;
    codes[4] = 4'b1111; codes[5] = 4'b0111; codes[6] = 4'b0011; codes[7] = 4'b0001;

    // Reset values
    do_reset();
    check_all_zero("rst");

    // Lock acquisition and wrap 7 -> 0 -> 1
    for (int i = 0; i < 10; i++) begin
      sample(codes[i % 8], 1'b1);
      check($sformatf("seq%0d_phase", i),  32'(bus.phase),        32'(i % 8));
      check($sformatf("seq%0d_onehot", i), 32'(bus.phase_onehot), 32'(8'b1 << (i % 8)));
      check($sformatf("seq%0d_pvalid", i), 32'(bus.phase_valid),  32'd1);
      check($sformatf("seq%0d_locked", i), 32'(bus.locked),       (i >= 4) ? 32'd1 : 32'd0);
      check($sformatf("seq%0d_errp", i),   32'(bus.err_pulse),    32'd0);
    end

    // Single illegal glitch while locked (last phase 1, expecting 2)
    sample(4'b1010, 1'b1);
    check("glitch_errp",   32'(bus.err_pulse),   32'd1);
    check("glitch_errc",   32'(bus.err_count),   32'd1);
    check("glitch_pvalid", 32'(bus.phase_valid), 32'd0);
    check("glitch_phase",  32'(bus.phase),       32'd1);
    check("glitch_locked", 32'(bus.locked),      32'd1);
    sample(codes[2], 1'b1);
    check("resume_errp",   32'(bus.err_pulse),   32'd0);
    check("resume_pvalid", 32'(bus.phase_valid), 32'd1);
    check("resume_phase",  32'(bus.phase),       32'd2);
    check("resume_locked", 32'(bus.locked),      32'd1);
    sample(codes[3], 1'b1);
    check("resume2_locked", 32'(bus.locked),     32'd1);

    // Upstream stuck at 0000 (expecting 4); err_count already holds 1
    sample(4'b0000, 1'b1);
    check("stuck1_errp",   32'(bus.err_pulse), 32'd1);
    check("stuck1_locked", 32'(bus.locked),    32'd1);
    check("stuck1_errc",   32'(bus.err_count), 32'd2);
    sample(4'b0000, 1'b1);
    check("stuck2_errp",   32'(bus.err_pulse), 32'd1);
    check("stuck2_locked", 32'(bus.locked),    32'd0);
    check("stuck2_errc",   32'(bus.err_count), 32'd3);
    sample(4'b0000, 1'b1);
    check("stuck3_errp",   32'(bus.err_pulse), 32'd0);
    check("stuck3_locked", 32'(bus.locked),    32'd0);
    check("stuck3_errc",   32'(bus.err_count), 32'd3);

    // Gapped valid: lock after seed + 4 in-sequence valid samples
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sample(codes[i], 1'b1);
      check($sformatf("gap%0d_phase", i),  32'(bus.phase),  32'(i));
      check($sformatf("gap%0d_locked", i), 32'(bus.locked), (i >= 4) ? 32'd1 : 32'd0);
      sample(4'b1010, 1'b0);
      check($sformatf("idle%0d_phase", i),  32'(bus.phase),        32'(i));
      check($sformatf("idle%0d_onehot", i), 32'(bus.phase_onehot), 32'(8'b1 << i));
      check($sformatf("idle%0d_pvalid", i), 32'(bus.phase_valid),  32'd1);
      check($sformatf("idle%0d_locked", i), 32'(bus.locked),       (i >= 4) ? 32'd1 : 32'd0);
      check($sformatf("idle%0d_errp", i),   32'(bus.err_pulse),    32'd0);
      check($sformatf("idle%0d_errc", i),   32'(bus.err_count),    32'd0);
    end

    // Saturation: 300 illegal samples, each followed by the expected phase
    ph = 5;
    for (int i = 0; i < 300; i++) begin
      sample(4'b1010, 1'b1);
      if (i == 254 || i == 299) begin
        check($sformatf("sat%0d_errp", i), 32'(bus.err_pulse), 32'd1);
        check($sformatf("sat%0d_errc", i), 32'(bus.err_count), 32'd255);
      end
      sample(codes[ph], 1'b1);
      ph = (ph + 1) % 8;
    end
    check("sat_locked", 32'(bus.locked),    32'd1);
    check("sat_errc",   32'(bus.err_count), 32'd255);

    // Asynchronous reset mid-cycle during an err_pulse cycle
    sample(4'b1010, 1'b1);
    check("prerst_errp", 32'(bus.err_pulse), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async");
    k = 0;
    sample(codes[0], 1'b1);
    check_all_zero("held");
    #3;
    reset_n = 1'b1;
    sample(4'b0000, 1'b0);
    check("post_locked", 32'(bus.locked),      32'(k));
    check("post_pvalid", 32'(bus.phase_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
